// File: rtl/rv32i_pipe_ctrl.sv
// RV32I pipeline hazard controller: load-use stall, data-memory wait, branch redirect.
// Stall/flush/pc_sel are combinational from state and inputs; mem_err and the perf counters are registered.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles / flush_count counters; otherwise both ports read 0.
module rv32i_pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic        ex_we,
   input  logic [4:0]  ex_waddr,
   input  logic        ex_memce,
   input  logic        ex_memwe,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        stall_if,
   output logic        stall_id,
   output logic        stall_ex,
   output logic        stall_mem,
   output logic        flush_id,
   output logic        flush_ex,
   output logic        pc_sel,
   output logic        mem_err,
   output logic [1:0]  state,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDUSE   = 2'd1,
      MEMWAIT = 2'd2,
      REDIR   = 2'd3
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic       redir_pend_q;
   logic       redir_pend_d;
   logic [7:0] wait_cnt_q;
   logic [7:0] wait_cnt_d;
   logic       mem_err_q;
   logic       timeout;

   logic       rs1_hit;
   logic       rs2_hit;
   logic       load_use;
   logic       memstall;

   // Only a load (read, with writeback to a non-zero register) creates a load-use hazard.
   assign rs1_hit  = id_rs1_used & (id_rs1_addr == ex_waddr);
   assign rs2_hit  = id_rs2_used & (id_rs2_addr == ex_waddr);
   assign load_use = ex_memce & ~ex_memwe & ex_we & (ex_waddr != 5'd0) & (rs1_hit | rs2_hit);
   assign memstall = mem_req & ~mem_ready;

   always_comb begin
      state_d      = state_q;
      redir_pend_d = redir_pend_q;
      wait_cnt_d   = wait_cnt_q;
      timeout      = 1'b0;
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      stall_ex     = 1'b0;
      stall_mem    = 1'b0;
      flush_id     = 1'b0;
      flush_ex     = 1'b0;
      pc_sel       = 1'b0;

      if (!rst) begin
         unique case (state_q)
            RUN, LDUSE: begin
               if (memstall) begin
                  stall_if   = 1'b1;
                  stall_id   = 1'b1;
                  stall_ex   = 1'b1;
                  stall_mem  = 1'b1;
                  wait_cnt_d = 8'd0;
                  state_d    = MEMWAIT;
               end else if (ex_branch_taken) begin
                  pc_sel   = 1'b1;
                  flush_id = 1'b1;
                  flush_ex = 1'b1;
                  state_d  = REDIR;
               end else if (load_use) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  flush_ex = 1'b1;
                  state_d  = LDUSE;
               end else begin
                  state_d = RUN;
               end
            end

            MEMWAIT: begin
               if (memstall && wait_cnt_q != 8'hFF) begin
                  stall_if   = 1'b1;
                  stall_id   = 1'b1;
                  stall_ex   = 1'b1;
                  stall_mem  = 1'b1;
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end else begin
                  // Completion or timeout: release the pipe and resume any deferred redirect.
                  timeout = memstall;
                  if (redir_pend_q) begin
                     redir_pend_d = 1'b0;
                     state_d      = REDIR;
                  end else begin
                     state_d = RUN;
                  end
               end
            end

            REDIR: begin
               if (memstall) begin
                  stall_if     = 1'b1;
                  stall_id     = 1'b1;
                  stall_ex     = 1'b1;
                  stall_mem    = 1'b1;
                  redir_pend_d = 1'b1;
                  wait_cnt_d   = 8'd0;
                  state_d      = MEMWAIT;
               end else begin
                  flush_id = 1'b1;
                  state_d  = RUN;
               end
            end

            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         redir_pend_q <= 1'b0;
         wait_cnt_q   <= 8'd0;
         mem_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         redir_pend_q <= redir_pend_d;
         wait_cnt_q   <= wait_cnt_d;
         mem_err_q    <= timeout;
      end
   end

   assign state   = state_q;
   assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_count_q;
   logic        enter_redir;

   assign enter_redir = ~rst & (state_d == REDIR) & (state_q != REDIR);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         if (stall_if && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (enter_redir && flush_count_q != 32'hFFFF_FFFF) begin
            flush_count_q <= flush_count_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Randomized + directed bench for rv32i_pipe_ctrl; a reference model queues expected outputs, a monitor checks them.
module tb_rv32i_pipe_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_waddr;
   logic        id_rs1_used, id_rs2_used, ex_we, ex_memce, ex_memwe;
   logic        ex_branch_taken, mem_req, mem_ready;
   logic        stall_if, stall_id, stall_ex, stall_mem;
   logic        flush_id, flush_ex, pc_sel, mem_err;
   logic [1:0]  state;
   logic [31:0] stall_cycles, flush_count;

   rv32i_pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_memce(ex_memce), .ex_memwe(ex_memwe),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .flush_id(flush_id), .flush_ex(flush_ex), .pc_sel(pc_sel), .mem_err(mem_err),
      .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       we;
      logic [4:0] waddr;
      logic       memce;
      logic       memwe;
      logic       br;
      logic       req;
      logic       rdy;
      logic       rst;
   } stim_t;

   typedef struct packed {
      logic [3:0]  stall;   // if, id, ex, mem
      logic        fid;
      logic        fex;
      logic        pc;
      logic        err;
      logic [1:0]  st;
      logic [31:0] sc;
      logic [31:0] fc;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   stim_t cur;

   // Reference model: phase numbers follow the architectural state codes RUN/LDUSE/MEMWAIT/REDIR = 0..3.
   int     m_ph, m_wait, n_ph, n_wait;
   bit     m_pend, m_err, n_pend, n_err;
   longint m_sc, m_fc, n_sc, n_fc;

   function automatic longint sat_inc(longint v, bit inc);
      if (inc && v < 64'h0000_0000_FFFF_FFFF) return v + 1;
      return v;
   endfunction

   task automatic apply(input stim_t s);
      id_rs1_addr = s.rs1;   id_rs2_addr = s.rs2;
      id_rs1_used = s.u1;    id_rs2_used = s.u2;
      ex_we = s.we;          ex_waddr = s.waddr;
      ex_memce = s.memce;    ex_memwe = s.memwe;
      ex_branch_taken = s.br;
      mem_req = s.req;       mem_ready = s.rdy;
      rst = s.rst;
   endtask

   task automatic evaluate(output obs_t o);
      bit lu, ms, tmo, leave;
      bit [3:0] stl;
      bit fid, fex, pc;
      lu = cur.memce && !cur.memwe && cur.we && cur.waddr != 0 &&
           ((cur.u1 && cur.rs1 == cur.waddr) || (cur.u2 && cur.rs2 == cur.waddr));
      ms = cur.req && !cur.rdy;
      stl = 4'b0000; fid = 0; fex = 0; pc = 0; tmo = 0; leave = 0;
      n_ph = m_ph; n_wait = m_wait; n_pend = m_pend;
      if (!cur.rst) begin
         if (m_ph == 0 || m_ph == 1) begin
            if (ms)          begin stl = 4'b1111; n_wait = 0; n_ph = 2; end
            else if (cur.br) begin pc = 1; fid = 1; fex = 1; n_ph = 3; end
            else if (lu)     begin stl = 4'b1100; fex = 1; n_ph = 1; end
            else             n_ph = 0;
         end else if (m_ph == 2) begin
            if (ms && m_wait == 255) begin tmo = 1; leave = 1; end
            else if (ms)             begin stl = 4'b1111; n_wait = m_wait + 1; end
            else                     leave = 1;
            if (leave) begin
               n_ph   = m_pend ? 3 : 0;
               n_pend = 0;
            end
         end else begin
            if (ms) begin stl = 4'b1111; n_pend = 1; n_wait = 0; n_ph = 2; end
            else    begin fid = 1; n_ph = 0; end
         end
      end
      o.stall = stl; o.fid = fid; o.fex = fex; o.pc = pc;
      o.err = m_err; o.st = m_ph[1:0];
      o.sc = m_sc[31:0]; o.fc = m_fc[31:0];
      if (cur.rst) begin
         n_ph = 0; n_wait = 0; n_pend = 0; n_err = 0; n_sc = 0; n_fc = 0;
      end else begin
         n_err = tmo;
         n_sc  = PERF ? sat_inc(m_sc, stl[3]) : 0;
         n_fc  = PERF ? sat_inc(m_fc, n_ph == 3) : 0;
      end
   endtask

   task automatic step(input stim_t s, input string tag);
      obs_t o;
      @(posedge clk);
      #1;
      m_ph = n_ph; m_wait = n_wait; m_pend = n_pend; m_err = n_err; m_sc = n_sc; m_fc = n_fc;
      cur = s;
      apply(s);
      evaluate(o);
      exp_q.push_back(o);
      tag_q.push_back(tag);
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.waddr = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.we    = ($urandom_range(0, 3) != 0);
      s.memce = 1'($urandom_range(0, 1));
      s.memwe = ($urandom_range(0, 3) == 0);
      s.br    = ($urandom_range(0, 7) == 0);
      s.req   = ($urandom_range(0, 3) == 0);
      s.rdy   = 1'($urandom_range(0, 1));
      s.rst   = ($urandom_range(0, 79) == 0);
      return s;
   endfunction

   // Monitor: compares every presented cycle against the oldest queued expectation.
   initial begin
      obs_t  e, g;
      string t;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, pc_sel,
                 mem_err, state, stall_cycles, flush_count};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL %s: got stall=%b fid=%b fex=%b pc=%b err=%b st=%0d sc=%0d fc=%0d, required stall=%b fid=%b fex=%b pc=%b err=%b st=%0d sc=%0d fc=%0d",
                        t, g.stall, g.fid, g.fex, g.pc, g.err, g.st, g.sc, g.fc,
                        e.stall, e.fid, e.fex, e.pc, e.err, e.st, e.sc, e.fc);
            end
         end
      end
   end

   initial begin
      stim_t s;
      obs_t  dummy;
      m_ph = 0; m_wait = 0; m_pend = 0; m_err = 0; m_sc = 0; m_fc = 0;
      cur = idle_stim();
      cur.rst = 1'b1;
      apply(cur);
      evaluate(dummy);

      // Reset cycle with hazards present: outputs must stay quiet.
      s = idle_stim(); s.rst = 1; s.br = 1; s.req = 1;
      step(s, "reset_gating");
      step(idle_stim(), "reset_state");

      // Load x5 in EX, ID reads x5.
      s = idle_stim(); s.memce = 1; s.we = 1; s.waddr = 5; s.rs1 = 5; s.u1 = 1;
      step(s, "load_use");
      step(idle_stim(), "load_use_release");
      step(idle_stim(), "load_use_run");

      // Same with destination x0: no hazard.
      s.waddr = 0; s.rs1 = 0;
      step(s, "load_x0");
      step(idle_stim(), "load_x0_after");

      // Branch together with a load-use hazard: branch wins.
      s = idle_stim(); s.memce = 1; s.we = 1; s.waddr = 7; s.rs2 = 7; s.u2 = 1; s.br = 1;
      step(s, "branch_over_lduse");
      s.br = 1;
      step(s, "redir_ignores_events");
      step(idle_stim(), "branch_back_run");

      // Three stalled cycles then completion.
      s = idle_stim(); s.req = 1;
      for (int i = 0; i < 3; i++) step(s, "memwait_stall");
      s.rdy = 1;
      step(s, "memwait_ready");
      step(idle_stim(), "memwait_done");

      // Memory never answers: timeout after 256 stalled cycles.
      s = idle_stim(); s.req = 1;
      for (int i = 0; i < 257; i++) step(s, "timeout_wait");
      step(idle_stim(), "timeout_err_pulse");
      step(idle_stim(), "timeout_err_clear");

      // Branch, memstall during REDIR, ready after 2 cycles, redirect resumes.
      s = idle_stim(); s.br = 1;
      step(s, "branch2");
      s = idle_stim(); s.req = 1;
      step(s, "redir_memstall");
      step(s, "redir_memwait");
      s.rdy = 1;
      step(s, "redir_mem_ready");
      step(idle_stim(), "redir_resumed");
      step(idle_stim(), "redir_resumed_run");

      // Reset in the middle of a memory wait.
      s = idle_stim(); s.req = 1;
      for (int i = 0; i < 3; i++) step(s, "pre_reset_wait");
      s.rst = 1;
      step(s, "reset_mid_wait");
      step(idle_stim(), "after_reset");

      for (int i = 0; i < 2000; i++) step(rand_stim(), "random");

      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
